// File: rtl/l1_mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// l1_mem_arb_defs
// Shared definitions for the L1 memory-port arbiter:
//   - port IDs: 0 = instruction cache, 1 = data cache
//   - arbiter FSM state encodings
//   - helper mapping a port ID to the state that owns the port for it
// ----------------------------------------------------------------------------
package l1_mem_arb_defs;

    localparam logic PORT_INSN = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e own_state(input logic port);
        return (port == PORT_DATA) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/l1_mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// l1_mem_port_arbiter_if
// Bundles both L1 request/response ports, the shared memory port and the
// underflow status flag. Signal names are written from the arbiter's side
// (i* = into the arbiter, o* = out of the arbiter).
//   modport slave  : the arbiter
//   modport master : the surroundings (both L1 caches and the memory front end)
// ----------------------------------------------------------------------------
interface l1_mem_port_arbiter_if;

    // Requester 0 (instruction cache)
    logic        iR0_REQ;
    logic        oR0_LOCK;
    logic [1:0]  iR0_ORDER;
    logic        iR0_RW;
    logic [13:0] iR0_TID;
    logic [1:0]  iR0_MMUMOD;
    logic [31:0] iR0_PDT;
    logic [31:0] iR0_ADDR;
    logic [31:0] iR0_DATA;
    logic        oR0_VALID;
    logic [63:0] oR0_DATA;

    // Requester 1 (data cache)
    logic        iR1_REQ;
    logic        oR1_LOCK;
    logic [1:0]  iR1_ORDER;
    logic        iR1_RW;
    logic [13:0] iR1_TID;
    logic [1:0]  iR1_MMUMOD;
    logic [31:0] iR1_PDT;
    logic [31:0] iR1_ADDR;
    logic [31:0] iR1_DATA;
    logic        oR1_VALID;
    logic [63:0] oR1_DATA;

    // Shared memory port
    logic        oMEM_REQ;
    logic [1:0]  oMEM_ORDER;
    logic        oMEM_RW;
    logic [13:0] oMEM_TID;
    logic [1:0]  oMEM_MMUMOD;
    logic [31:0] oMEM_PDT;
    logic [31:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic        iMEM_LOCK;
    logic        iMEM_VALID;
    logic [63:0] iMEM_DATA;

    logic        oERR_UNDERFLOW;

    modport slave (
        input  iR0_REQ, iR0_ORDER, iR0_RW, iR0_TID, iR0_MMUMOD, iR0_PDT, iR0_ADDR, iR0_DATA,
        input  iR1_REQ, iR1_ORDER, iR1_RW, iR1_TID, iR1_MMUMOD, iR1_PDT, iR1_ADDR, iR1_DATA,
        input  iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        output oR0_LOCK, oR0_VALID, oR0_DATA, oR1_LOCK, oR1_VALID, oR1_DATA,
        output oMEM_REQ, oMEM_ORDER, oMEM_RW, oMEM_TID, oMEM_MMUMOD, oMEM_PDT,
        output oMEM_ADDR, oMEM_DATA, oERR_UNDERFLOW
    );

    modport master (
        output iR0_REQ, iR0_ORDER, iR0_RW, iR0_TID, iR0_MMUMOD, iR0_PDT, iR0_ADDR, iR0_DATA,
        output iR1_REQ, iR1_ORDER, iR1_RW, iR1_TID, iR1_MMUMOD, iR1_PDT, iR1_ADDR, iR1_DATA,
        output iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        input  oR0_LOCK, oR0_VALID, oR0_DATA, oR1_LOCK, oR1_VALID, oR1_DATA,
        input  oMEM_REQ, oMEM_ORDER, oMEM_RW, oMEM_TID, oMEM_MMUMOD, oMEM_PDT,
        input  oMEM_ADDR, oMEM_DATA, oERR_UNDERFLOW
    );

endinterface

// File: rtl/l1_mem_port_arbiter_owner_fifo.sv
// ----------------------------------------------------------------------------
// l1_mem_arb_owner_fifo
// In-order record of which port issued each accepted memory transaction.
// 1 bit wide, P_FIFO_DEPTH deep (power of two), pointers wrap naturally.
// Ports:
//   iCLOCK, inRESET : clock, asynchronous active-low reset
//   push_i, push_data_i : write one owner bit (ignored when full)
//   pop_i           : drop the head entry (ignored when empty)
//   full_o, empty_o : status from the registered count
//   head_o          : owner of the oldest outstanding transaction
//   count_o         : number of stored entries (0..P_FIFO_DEPTH)
// ----------------------------------------------------------------------------
module l1_mem_arb_owner_fifo #(
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_FIFO_AW    = 4
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               push_i,
    input  logic               push_data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic               head_o,
    output logic [P_FIFO_AW:0] count_o
);
    localparam logic [P_FIFO_AW:0] DEPTH_CNT = (P_FIFO_AW+1)'(P_FIFO_DEPTH);

    logic                 mem_q [P_FIFO_DEPTH];
    logic [P_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [P_FIFO_AW:0]   count_q;
    logic                 push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head is read combinationally so a response can be steered in the
    // same cycle it arrives.
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even if a pop frees a slot this cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge iCLOCK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/l1_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// l1_mem_port_arbiter
// Shares one memory request/response port between the L1 I-cache (port 0)
// and the L1 D-cache (port 1). Round-robin grant held across bursts of up to
// P_BURST_MAX accepted beats; owner of every accepted beat is queued so the
// in-order responses can be steered back to the right cache.
// Ports:
//   iCLOCK  : clock (rising edge)
//   inRESET : asynchronous active-low reset
//   bus     : l1_mem_port_arbiter_if.slave (both requesters, memory port,
//             oERR_UNDERFLOW sticky flag)
// ----------------------------------------------------------------------------
module l1_mem_port_arbiter
    import l1_mem_arb_defs::*;
#(
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_FIFO_AW    = 4,
    parameter int P_BURST_MAX  = 8
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    l1_mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] BURST_CNT = 4'(P_BURST_MAX);

    arb_state_e         state_q, state_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic               last_q, last_d;
    logic               err_q;

    logic [1:0]         req;
    logic               sel, in_grant, mem_req, accept, pop;
    logic               fifo_full, fifo_empty, fifo_head;
    logic [P_FIFO_AW:0] fifo_count;
    logic [1:0]         lock_w, valid_w;

    assign req = {bus.iR1_REQ, bus.iR0_REQ};

    // Port selection: owner while a burst is held, otherwise round-robin
    // (the port that was not served last wins a tie).
    always_comb begin
        sel = PORT_INSN;
        case (state_q)
            OWN0:    sel = PORT_INSN;
            OWN1:    sel = PORT_DATA;
            default: begin
                if (req[1] && !req[0])     sel = PORT_DATA;
                else if (req[1] && req[0]) sel = !last_q;
            end
        endcase
    end

    // Once a burst reaches P_BURST_MAX the owner state stays for one more
    // cycle with the grant withdrawn; that cycle is the handover dead cycle,
    // exactly like the cycle where an owner drops its request.
    always_comb begin
        in_grant = 1'b0;
        case (state_q)
            IDLE:       in_grant = 1'b1;
            OWN0, OWN1: in_grant = (state_q == own_state(sel)) && (beat_cnt_q < BURST_CNT);
            default:    in_grant = 1'b0;
        endcase
    end

    assign mem_req = req[sel] && in_grant;
    assign accept  = mem_req && !bus.iMEM_LOCK && !fifo_full;
    assign pop     = bus.iMEM_VALID && !fifo_empty;

    assign bus.oMEM_REQ    = mem_req;
    assign bus.oMEM_ORDER  = sel ? bus.iR1_ORDER  : bus.iR0_ORDER;
    assign bus.oMEM_RW     = sel ? bus.iR1_RW     : bus.iR0_RW;
    assign bus.oMEM_TID    = sel ? bus.iR1_TID    : bus.iR0_TID;
    assign bus.oMEM_MMUMOD = sel ? bus.iR1_MMUMOD : bus.iR0_MMUMOD;
    assign bus.oMEM_PDT    = sel ? bus.iR1_PDT    : bus.iR0_PDT;
    assign bus.oMEM_ADDR   = sel ? bus.iR1_ADDR   : bus.iR0_ADDR;
    assign bus.oMEM_DATA   = sel ? bus.iR1_DATA   : bus.iR0_DATA;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = own_state(sel);
                    beat_cnt_d = 4'd1;
                    last_d     = sel;
                end
            end
            OWN0, OWN1: begin
                if (!req[sel] || beat_cnt_q >= BURST_CNT) begin
                    state_d    = IDLE;
                    beat_cnt_d = 4'd0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q    <= IDLE;
            beat_cnt_q <= 4'd0;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
            // A response with nothing outstanding is dropped and flagged.
            if (bus.iMEM_VALID && fifo_count == '0) err_q <= 1'b1;
        end
    end

    l1_mem_arb_owner_fifo #(
        .P_FIFO_DEPTH (P_FIFO_DEPTH),
        .P_FIFO_AW    (P_FIFO_AW)
    ) u_owner_fifo (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .push_i      (accept),
        .push_data_i (sel),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign lock_w[gi]  = req[gi] && !(accept && sel == 1'(gi));
        assign valid_w[gi] = pop && (fifo_head == 1'(gi));
    end

    assign bus.oR0_LOCK       = lock_w[0];
    assign bus.oR1_LOCK       = lock_w[1];
    assign bus.oR0_VALID      = valid_w[0];
    assign bus.oR1_VALID      = valid_w[1];
    assign bus.oR0_DATA       = bus.iMEM_DATA;
    assign bus.oR1_DATA       = bus.iMEM_DATA;
    assign bus.oERR_UNDERFLOW = err_q;

endmodule

// File: tb/tb_l1_mem_port_arbiter.sv
module tb_l1_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l1_mem_port_arbiter_if bus();

    l1_mem_port_arbiter #(
        .P_FIFO_DEPTH (16),
        .P_FIFO_AW    (4),
        .P_BURST_MAX  (8)
    ) dut (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Per-cycle masks: bit c = event seen in cycle c of the current test.
    logic [31:0] m_a0, m_a1, m_l0, m_v0, m_v1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        bus.iR0_REQ    = 1'b0;  bus.iR1_REQ    = 1'b0;
        bus.iR0_ORDER  = 2'd3;  bus.iR1_ORDER  = 2'd2;
        bus.iR0_RW     = 1'b1;  bus.iR1_RW     = 1'b0;
        bus.iR0_TID    = 14'h0155; bus.iR1_TID = 14'h02AB;
        bus.iR0_MMUMOD = 2'd1;  bus.iR1_MMUMOD = 2'd2;
        bus.iR0_PDT    = 32'hA000_0000; bus.iR1_PDT  = 32'hB000_0000;
        bus.iR0_ADDR   = 32'h1000_0000; bus.iR1_ADDR = 32'h2000_0000;
        bus.iR0_DATA   = 32'h0D0D_0000; bus.iR1_DATA = 32'h1D1D_0000;
        bus.iMEM_LOCK  = 1'b0;
        bus.iMEM_VALID = 1'b0;
        bus.iMEM_DATA  = 64'h0;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        m_a0 = '0; m_a1 = '0; m_l0 = '0; m_v0 = '0; m_v1 = '0;
    endtask

    task automatic sample(input int c);
        m_a0[c] = bus.iR0_REQ && !bus.oR0_LOCK;
        m_a1[c] = bus.iR1_REQ && !bus.oR1_LOCK;
        m_l0[c] = bus.oR0_LOCK;
        m_v0[c] = bus.oR0_VALID;
        m_v1[c] = bus.oR1_VALID;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev;
        idle_inputs();
        rst_n = 1'b0;
        #6;

        // ---------------- reset state ----------------
        do_reset();
        #2;
        check_eq("rst_memreq_idle", bus.oMEM_REQ, 1'b0);
        check_eq("rst_lock0", bus.oR0_LOCK, 1'b0);
        check_eq("rst_valid0", bus.oR0_VALID, 1'b0);
        check_eq("rst_valid1", bus.oR1_VALID, 1'b0);
        check_eq("rst_underflow", bus.oERR_UNDERFLOW, 1'b0);
        check_eq("rst_addr_port0", bus.oMEM_ADDR, 32'h1000_0000);
        bus.iR0_REQ = 1'b1;
        #1;
        check_eq("rst_memreq_tracks", bus.oMEM_REQ, 1'b1);

        // ---------------- port 0 alone ----------------
        for (int c = 0; c < 10; c++) begin
            bus.iR0_REQ  = 1'b1;
            bus.iR0_ADDR = 32'h1000_0000 + 32'(c);
            #2;
            sample(c);
            if (c == 3) check_eq("t1_addr_mux", bus.oMEM_ADDR, 32'h1000_0003);
            next_cycle();
        end
        check_eq("t1_acc0", m_a0[9:0], 10'b10_1111_1111);
        check_eq("t1_acc1", m_a1[9:0], 10'b0);
        bus.iR0_REQ = 1'b0;
        for (int c = 0; c < 9; c++) begin
            bus.iMEM_VALID = 1'b1;
            bus.iMEM_DATA  = 64'hD000_0000_0000_0000 | 64'(c);
            #2;
            sample(c);
            if (c == 2) check_eq("t1_rdata0", bus.oR0_DATA, 64'hD000_0000_0000_0002);
            next_cycle();
        end
        bus.iMEM_VALID = 1'b0;
        check_eq("t1_valid0", m_v0[8:0], 9'h1FF);
        check_eq("t1_valid1", m_v1[8:0], 9'h000);
        #2;
        check_eq("t1_no_underflow", bus.oERR_UNDERFLOW, 1'b0);
        next_cycle();

        // ---------------- both ports continuously, memory echoes next cycle ----------------
        do_reset();
        prev = 1'b0;
        for (int c = 0; c < 27; c++) begin
            bus.iR0_REQ    = 1'b1;
            bus.iR1_REQ    = 1'b1;
            bus.iMEM_VALID = prev;
            bus.iMEM_DATA  = 64'h5A5A_0000_0000_0000 | 64'(c);
            #2;
            sample(c);
            prev = m_a0[c] | m_a1[c];
            next_cycle();
        end
        idle_inputs();
        check_eq("t2_acc0", m_a0[26:0], 27'h3FC00FF);
        check_eq("t2_acc1", m_a1[26:0], 27'h001FE00);
        check_eq("t2_valid0", m_v0[26:0], 27'h7F801FE);
        check_eq("t2_valid1", m_v1[26:0], 27'h003FC00);
        #2;
        check_eq("t2_no_underflow", bus.oERR_UNDERFLOW, 1'b0);
        next_cycle();

        // ---------------- port 1 short burst, port 0 waiting ----------------
        do_reset();
        for (int c = 0; c < 6; c++) begin
            bus.iR1_REQ  = (c < 3);
            bus.iR0_REQ  = (c >= 1);
            bus.iR1_ADDR = 32'h2000_0000 + 32'(c);
            #2;
            sample(c);
            if (c == 1) begin
                check_eq("t3_addr_owner1", bus.oMEM_ADDR, 32'h2000_0001);
                check_eq("t3_rw_owner1", bus.oMEM_RW, 1'b0);
                check_eq("t3_tid_owner1", bus.oMEM_TID, 14'h02AB);
            end
            next_cycle();
        end
        check_eq("t3_acc1", m_a1[5:0], 6'b000111);
        check_eq("t3_acc0", m_a0[5:0], 6'b110000);
        check_eq("t3_lock0", m_l0[5:0], 6'b001110);
        bus.iR0_REQ = 1'b0;
        bus.iR1_REQ = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.iMEM_VALID = 1'b1;
            bus.iMEM_DATA  = 64'h3300_0000_0000_0000 | 64'(c);
            #2;
            sample(c);
            if (c == 1) check_eq("t3_rdata1", bus.oR1_DATA, 64'h3300_0000_0000_0001);
            next_cycle();
        end
        bus.iMEM_VALID = 1'b0;
        check_eq("t3_valid1", m_v1[4:0], 5'b00111);
        check_eq("t3_valid0", m_v0[4:0], 5'b11000);

        // ---------------- memory lock mid-burst ----------------
        do_reset();
        for (int c = 0; c < 15; c++) begin
            bus.iR0_REQ   = 1'b1;
            bus.iMEM_LOCK = (c >= 3 && c <= 7);
            #2;
            sample(c);
            next_cycle();
        end
        idle_inputs();
        check_eq("t4_acc0", m_a0[14:0], 15'h5F07);
        check_eq("t4_lock0", m_l0[14:0], 15'h20F8);

        // ---------------- owner FIFO full ----------------
        do_reset();
        for (int c = 0; c < 21; c++) begin
            bus.iR0_REQ    = 1'b1;
            bus.iMEM_VALID = (c == 19);
            bus.iMEM_DATA  = 64'h7700_0000_0000_0000;
            #2;
            sample(c);
            next_cycle();
        end
        idle_inputs();
        check_eq("t5_acc0", m_a0[20:0], 21'h11FEFF);
        check_eq("t5_lock0", m_l0[20:0], 21'h0E0100);
        check_eq("t5_valid0", m_v0[20:0], 21'h080000);

        // ---------------- response with empty FIFO ----------------
        do_reset();
        bus.iMEM_VALID = 1'b1;
        #2;
        check_eq("t6_valid0_empty", bus.oR0_VALID, 1'b0);
        check_eq("t6_valid1_empty", bus.oR1_VALID, 1'b0);
        check_eq("t6_flag_before_edge", bus.oERR_UNDERFLOW, 1'b0);
        next_cycle();
        bus.iMEM_VALID = 1'b0;
        #2;
        check_eq("t6_underflow_set", bus.oERR_UNDERFLOW, 1'b1);
        next_cycle();
        next_cycle();
        next_cycle();
        #2;
        check_eq("t6_underflow_sticky", bus.oERR_UNDERFLOW, 1'b1);
        next_cycle();
        do_reset();
        #2;
        check_eq("t6_underflow_cleared", bus.oERR_UNDERFLOW, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
